// File: rtl/mem_responder.sv
// Memory-side responder for the cpu bus: req/ready handshake in front of a word RAM
// with a fixed number of wait states. Define MEM_ROM_PROTECT_EN to write-protect the low ROM_WORDS words.
module mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ROM_WORDS   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr_in_c;
  logic [ADDR_W-1:0]   resp_addr_c;
  logic                resp_rw_c;
  logic                enter_resp_c;
  logic                rom_hit_c;
  logic                unused_addr_hi;

  // Upper address bits alias onto the same word.
  assign addr_in_c      = address[ADDR_W-1:0];
  assign unused_addr_hi = ^address[31:ADDR_W];

  // With zero wait states the transfer enters RESP straight from IDLE, before the
  // latches are loaded, so the live request fields are used for that transition.
  assign enter_resp_c = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && (cnt == CNT_W'(1)));
  assign resp_addr_c  = (state == IDLE) ? addr_in_c : addr_q;
  assign resp_rw_c    = (state == IDLE) ? rw : rw_q;

`ifdef MEM_ROM_PROTECT_EN
  assign rom_hit_c = resp_rw_c && (32'(resp_addr_c) < ROM_WORDS);
`else
  assign rom_hit_c = 1'b0;
`endif

  // Handshake FSM; ready/err/rdata are registered so they are valid in the RESP cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr_in_c;
            rw_q    <= rw;
            wdata_q <= wdata;
            cnt     <= CNT_W'(WAIT_STATES);
            state   <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp_c) begin
        ready <= 1'b1;
        err   <= rom_hit_c;
        if (!resp_rw_c) begin
          rdata <= mem[resp_addr_c];
        end
      end
    end
  end

  // Write commits on the edge ending RESP; a coincident reset or a protected address drops it.
  always_ff @(posedge clock) begin
    if (!reset && (state == RESP) && rw_q && !err) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: latency, data, aliasing, reset abort, ROM protection,
// and back-to-back throughput on 0- and 3-wait-state instances.
module tb_mem_responder;

  localparam int unsigned WS = 1;

  logic        clock = 1'b0;
  logic        reset, req, req_b, rw;
  logic [31:0] address, wdata;
  logic [31:0] rdata, rdata0, rdata3;
  logic        ready, ready0, ready3;
  logic        err, err0, err3;

  always #5 clock = ~clock;

  mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(WS), .ROM_WORDS(64)) dut (
    .clock(clock), .reset(reset), .req(req), .rw(rw), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err));

  mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(0), .ROM_WORDS(64)) dut0 (
    .clock(clock), .reset(reset), .req(req_b), .rw(rw), .address(address),
    .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0));

  mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(3), .ROM_WORDS(64)) dut3 (
    .clock(clock), .reset(reset), .req(req_b), .rw(rw), .address(address),
    .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3));

  typedef struct {
    logic [31:0] rd;
    logic        er;
    logic        chk_rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd;
  logic [31:0] captured;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every ready pulse of the main instance consumes one expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_rd) check("sb_rdata", rdata, e.rd);
        else captured = rdata;
        check("sb_err", {31'b0, err}, {31'b0, e.er});
      end
    end
  end

  // One transfer on the main instance; returns at the negedge where ready is seen.
  // Latency is counted in posedges after the accepting edge and must equal WS.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic chk = 1'b1);
    exp_t e;
    int   k;
    int   idx;
    logic rom;
    idx = int'(a & 32'h3FF);
    rom = 1'b0;
`ifdef MEM_ROM_PROTECT_EN
    rom = w && (idx < 64);
`endif
    if (!w) last_rd = chk ? model[idx] : 32'h0;
    else if (!rom) model[idx] = d;
    e.rd = last_rd;
    e.er = rom;
    e.chk_rd = chk;
    sb.push_back(e);
    @(negedge clock);
    req = 1'b1; rw = w; address = a; wdata = d;
    @(posedge clock);
    #1;
    req = 1'b0; rw = ~w; address = ~a; wdata = ~d;
    k = 0;
    @(negedge clock);
    while (ready !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("latency", 32'(k), 32'(WS));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last0, last3, cnt0, cnt3, first0, first3;
    reset = 1'b1; req = 1'b1; req_b = 1'b1; rw = 1'b0; address = 32'h0; wdata = 32'h0;
    last_rd = 32'h0; captured = 32'h0;

    // Reset held with req high.
    repeat (3) begin
      @(posedge clock);
      #1;
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0; req = 1'b0; req_b = 1'b0;

    // Back-to-back reads on 0 and 3 wait states with req held.
    @(negedge clock);
    req_b = 1'b1; rw = 1'b1; address = 32'h55; wdata = 32'hCAFE_F00D;
    @(posedge clock);
    #1 req_b = 1'b0;
    repeat (8) @(negedge clock);
    rw = 1'b0; address = 32'h55; req_b = 1'b1;
    last0 = -1; last3 = -1; cnt0 = 0; cnt3 = 0; first0 = -1; first3 = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clock);
      if (ready0) begin
        if (last0 >= 0) check("ws0_interval", 32'(cyc - last0), 32'd2);
        else first0 = cyc;
        check("ws0_rdata", rdata0, 32'hCAFE_F00D);
        last0 = cyc; cnt0++;
      end
      if (ready3) begin
        if (last3 >= 0) check("ws3_interval", 32'(cyc - last3), 32'd5);
        else first3 = cyc;
        check("ws3_rdata", rdata3, 32'hCAFE_F00D);
        last3 = cyc; cnt3++;
      end
    end
    req_b = 1'b0;
    check("ws0_first", 32'(first0), 32'd0);
    check("ws3_first", 32'(first3), 32'd3);
    check("ws0_count", 32'(cnt0), 32'd15);
    check("ws3_count", 32'(cnt3), 32'd6);
    repeat (8) @(negedge clock);

    // Basic write/read and several patterns.
    xfer(1'b1, 32'h100, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h100, 32'h0);
    xfer(1'b1, 32'h3FF, 32'h0BAD_F00D);
    xfer(1'b1, 32'h101, 32'h5A5A_A5A5);
    xfer(1'b0, 32'h3FF, 32'h0);
    xfer(1'b1, 32'h2F0, 32'h0000_0001);
    xfer(1'b0, 32'h101, 32'h0);
    xfer(1'b0, 32'h2F0, 32'h0);

    // Aliasing: 0x400 and 0x000 share a word.
    xfer(1'b1, 32'h400, 32'h1234_5678);
    xfer(1'b0, 32'h000, 32'h0);
    xfer(1'b0, 32'hFFFF_F400, 32'h0);

    // Reset during WAIT of a write: no ready, RAM keeps the prior value.
    xfer(1'b1, 32'h200, 32'h1111_2222);
    @(negedge clock);
    req = 1'b1; rw = 1'b1; address = 32'h200; wdata = 32'hAAAA_5555;
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_rdata", rdata, 32'd0);
    last_rd = 32'h0;
    repeat (4) begin
      @(negedge clock);
      check("abort_no_ready", {31'b0, ready}, 32'd0);
    end
    xfer(1'b0, 32'h200, 32'h0);

    // Reset coinciding with the RESP edge of a write: write not performed.
    xfer(1'b1, 32'h204, 32'h3333_4444);
    xfer(1'b1, 32'h204, 32'hBBBB_CCCC);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("resp_reset_ready", {31'b0, ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model[int'(32'h204)] = 32'h3333_4444;
    last_rd = 32'h0;
    xfer(1'b0, 32'h204, 32'h0);

    // Low-address write: protected or stored depending on build.
`ifdef MEM_ROM_PROTECT_EN
    xfer(1'b0, 32'h10, 32'h0, 1'b0);
    model[16] = captured;
    last_rd = captured;
`endif
    xfer(1'b1, 32'h10, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h10, 32'h0);
    xfer(1'b1, 32'h40, 32'h1357_9BDF);
    xfer(1'b0, 32'h40, 32'h0);

    repeat (4) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
